// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings for the multiply/divide unit
// Op and FSM encodings plus small op-decode helpers.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PREP = 2'b01,
    ST_CALC = 2'b10,
    ST_FIX  = 2'b11
  } state_e;

  localparam int MDU_ITER = 32;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one shift-add or restoring-subtract iteration
// Divide step exists only when MDU_DIV_EN is defined.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH:0]   acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   acc_hi_o,
  output logic [WIDTH-1:0] acc_lo_o
);

  logic [WIDTH:0] mul_sum;
`ifdef MDU_DIV_EN
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
  logic           unused_bits;
  assign unused_bits = acc_hi_i[WIDTH];
`else
  logic           unused_bits;
  assign unused_bits = acc_hi_i[WIDTH] ^ is_div_i;
`endif

  always_comb begin
    // Multiply: add multiplicand on LSB of the multiplier, shift the pair right
    mul_sum  = {1'b0, acc_hi_i[WIDTH-1:0]} + (acc_lo_i[0] ? {1'b0, b_i} : '0);
    acc_hi_o = {1'b0, mul_sum[WIDTH:1]};
    acc_lo_o = {mul_sum[0], acc_lo_i[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    div_shift = {acc_hi_i[WIDTH-1:0], acc_lo_i[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_i};
    if (is_div_i) begin
      // Borrow out of the top bit means the divisor did not fit: restore
      if (div_diff[WIDTH]) begin
        acc_hi_o = div_shift;
        acc_lo_o = {acc_lo_i[WIDTH-2:0], 1'b0};
      end else begin
        acc_hi_o = div_diff;
        acc_lo_o = {acc_lo_i[WIDTH-2:0], 1'b1};
      end
    end
`endif
  end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MIPS multiply/divide unit owning HI/LO
// Divide datapath is built only when MDU_DIV_EN is defined.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             quo_neg_q, quo_neg_d;
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
`ifdef MDU_DIV_EN
  logic             rem_neg_q, rem_neg_d;
  logic             divz_q, divz_d;
  logic [WIDTH-1:0] quo_fix, rem_fix;
`endif

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (op_is_div(op_q)),
    .acc_hi_i (acc_hi_q),
    .acc_lo_i (acc_lo_q),
    .b_i      (b_q),
    .acc_hi_o (step_hi),
    .acc_lo_o (step_lo)
  );

  // Operands are read straight from the register file ports during PREP
  assign sign_a   = op_is_signed(op_q) & opa_i[WIDTH-1];
  assign sign_b   = op_is_signed(op_q) & opb_i[WIDTH-1];
  assign mag_a    = sign_a ? -opa_i : opa_i;
  assign mag_b    = sign_b ? -opb_i : opb_i;
  assign prod     = {acc_hi_q[WIDTH-1:0], acc_lo_q};
  assign prod_fix = quo_neg_q ? -prod : prod;
`ifdef MDU_DIV_EN
  assign quo_fix  = quo_neg_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = rem_neg_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    quo_neg_d  = quo_neg_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    b_d        = b_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
`ifdef MDU_DIV_EN
    rem_neg_d  = rem_neg_q;
    divz_d     = divz_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          op_d = op_i;
`ifdef MDU_DIV_EN
          state_d = ST_PREP;
`else
          state_d = op_is_div(op_i) ? ST_FIX : ST_PREP;
`endif
        end else begin
          if (mthi_i) hi_d = opa_i;
          if (mtlo_i) lo_d = opa_i;
        end
      end
      ST_PREP: begin
        acc_hi_d  = '0;
        acc_lo_d  = mag_a;
        b_d       = mag_b;
        quo_neg_d = sign_a ^ sign_b;
`ifdef MDU_DIV_EN
        rem_neg_d = sign_a;
        divz_d    = (opb_i == '0);
`endif
        cnt_d     = CNT_W'(WIDTH - 1);
        state_d   = ST_CALC;
      end
      ST_CALC: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (!op_is_div(op_q)) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
`ifdef MDU_DIV_EN
        else if (divz_q) begin
          div_zero_d = 1'b1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      quo_neg_q  <= 1'b0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      b_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
`ifdef MDU_DIV_EN
      rem_neg_q  <= 1'b0;
      divz_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      quo_neg_q  <= quo_neg_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      b_q        <= b_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
`ifdef MDU_DIV_EN
      rem_neg_q  <= rem_neg_d;
      divz_q     <= divz_d;
`endif
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;
  assign div_zero_o = div_zero_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
// Arithmetic reference model plus directed vectors; honours MDU_DIV_EN.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int MUL_LAT = MDU_ITER + 3;
`ifdef MDU_DIV_EN
  localparam int DIV_LAT = MDU_ITER + 3;
`else
  localparam int DIV_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] opa_i = '0;
  logic [31:0] opb_i = '0;
  logic        mthi_i = 1'b0;
  logic        mtlo_i = 1'b0;
  logic        busy_o, done_o, div_zero_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .opa_i      (opa_i),
    .opb_i      (opb_i),
    .mthi_i     (mthi_i),
    .mtlo_i     (mtlo_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .div_zero_o (div_zero_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result of the whole operation appears after a fixed latency
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0, p_wr = 1'b0;
  int          m_left = 0;

  function automatic void predict(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] prod;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    p_dz = 1'b0;
    p_wr = 1'b1;
    case (op)
      2'b00: begin prod = sa * sb; p_hi = prod[63:32]; p_lo = prod[31:0]; end
      2'b01: begin prod = {32'b0, a} * {32'b0, b}; p_hi = prod[63:32]; p_lo = prod[31:0]; end
`ifdef MDU_DIV_EN
      2'b10: begin
        if (b == 0) begin p_dz = 1'b1; p_wr = 1'b0; end
        else begin q = sa / sb; r = sa % sb; p_lo = 32'(q); p_hi = 32'(r); end
      end
      default: begin
        if (b == 0) begin p_dz = 1'b1; p_wr = 1'b0; end
        else begin p_lo = a / b; p_hi = a % b; end
      end
`else
      default: p_wr = 1'b0;
`endif
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (m_left != 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_dz   = p_dz;
          if (p_wr) begin m_hi = p_hi; m_lo = p_lo; end
        end
      end else if (start_i) begin
        predict(op_i, opa_i, opb_i);
        m_left = op_i[1] ? DIV_LAT - 1 : MUL_LAT - 1;
        m_busy = 1'b1;
      end else begin
        if (mthi_i) m_hi = opa_i;
        if (mtlo_i) m_lo = opa_i;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy_o), 64'(m_busy));
    chk("done", 64'(done_o), 64'(m_done));
    chk("div_zero", 64'(div_zero_o), 64'(m_dz));
    chk("hi", 64'(hi_o), 64'(m_hi));
    chk("lo", 64'(lo_o), 64'(m_lo));
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic dz);
    @(posedge clk); #1;
    op_i = op; opa_i = a; opb_i = b; start_i = 1'b1;
    lat = -1;
    dz  = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (done_o) begin lat = i; dz = div_zero_o; break; end
    end
  endtask

  int   lat, ndone;
  logic dz;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", 64'(hi_o), 64'h0);
    chk("rst_lo", 64'(lo_o), 64'h0);
    chk("rst_busy", 64'(busy_o), 64'h0);
    chk("rst_done", 64'(done_o), 64'h0);
    rst = 1'b0;

    run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, lat, dz);
    chk("mult_lat", 64'(lat), 64'd35);
    chk("mult_hi", 64'(hi_o), 64'hFFFFFFFF);
    chk("mult_lo", 64'(lo_o), 64'hFFFFFFFA);

    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, dz);
    chk("multu_hi", 64'(hi_o), 64'hFFFFFFFE);
    chk("multu_lo", 64'(lo_o), 64'h00000001);

    run_op(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, dz);
    chk("mults_hi", 64'(hi_o), 64'h0);
    chk("mults_lo", 64'(lo_o), 64'h1);

    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, dz);
    chk("div_lat", 64'(lat), 64'(DIV_LAT));
`ifdef MDU_DIV_EN
    chk("div_lo", 64'(lo_o), 64'hFFFFFFFD);
    chk("div_hi", 64'(hi_o), 64'hFFFFFFFF);
`else
    chk("nodiv_lo", 64'(lo_o), 64'h1);
`endif

    run_op(OP_DIVU, 32'd7, 32'd2, lat, dz);
`ifdef MDU_DIV_EN
    chk("divu_lo", 64'(lo_o), 64'd3);
    chk("divu_hi", 64'(hi_o), 64'd1);
`endif

    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, dz);
`ifdef MDU_DIV_EN
    chk("ovf_lo", 64'(lo_o), 64'h80000000);
    chk("ovf_hi", 64'(hi_o), 64'h0);
`endif

    run_op(OP_DIVU, 32'd5, 32'd0, lat, dz);
`ifdef MDU_DIV_EN
    chk("dz_flag", 64'(dz), 64'h1);
    chk("dz_lo", 64'(lo_o), 64'h80000000);
    chk("dz_hi", 64'(hi_o), 64'h0);
`else
    chk("dz_flag", 64'(dz), 64'h0);
`endif

    @(posedge clk); #1;
    mthi_i = 1'b1; opa_i = 32'h1234;
    @(posedge clk); #1;
    mthi_i = 1'b0;
    chk("mthi_hi", 64'(hi_o), 64'h1234);
    chk("mthi_done", 64'(done_o), 64'h0);
    mthi_i = 1'b1; mtlo_i = 1'b1; opa_i = 32'hABCD;
    @(posedge clk); #1;
    mthi_i = 1'b0; mtlo_i = 1'b0;
    chk("mtboth_hi", 64'(hi_o), 64'hABCD);
    chk("mtboth_lo", 64'(lo_o), 64'hABCD);

    // start together with moves: moves are dropped
    @(posedge clk); #1;
    mthi_i = 1'b1; mtlo_i = 1'b1;
    run_op(OP_MULTU, 32'd2, 32'd3, lat, dz);
    mthi_i = 1'b0; mtlo_i = 1'b0;
    chk("startwin_lo", 64'(lo_o), 64'd6);

    // start and mthi while busy are ignored
    @(posedge clk); #1;
    op_i = OP_MULT; opa_i = 32'd100; opb_i = 32'hFFFFFFFD; start_i = 1'b1;
    ndone = 0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk); #1;
      start_i = (i == 5);
      mthi_i  = (i == 7);
      if (i == 5) begin op_i = OP_MULTU; opa_i = 32'd9; opb_i = 32'd9; end
      if (done_o) begin
        ndone++;
        chk("busyign_cycle", 64'(i), 64'd35);
      end
    end
    chk("busyign_ndone", 64'(ndone), 64'd1);
    chk("busyign_hi", 64'(hi_o), 64'hFFFFFFFF);
    chk("busyign_lo", 64'(lo_o), 64'hFFFFFED4);

    // asynchronous reset mid-operation
    @(posedge clk); #1;
`ifdef MDU_DIV_EN
    op_i = OP_DIV;
`else
    op_i = OP_MULT;
`endif
    opa_i = 32'd100; opb_i = 32'd7; start_i = 1'b1;
    repeat (10) begin @(posedge clk); #1; start_i = 1'b0; end
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy_o), 64'h0);
    chk("abort_hi", 64'(hi_o), 64'h0);
    chk("abort_lo", 64'(lo_o), 64'h0);
    ndone = 0;
    repeat (3) begin @(posedge clk); #1; if (done_o) ndone++; end
    rst = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done_o) ndone++; end
    chk("abort_nodone", 64'(ndone), 64'h0);

    run_op(OP_MULTU, 32'd3, 32'd4, lat, dz);
    chk("post_lo", 64'(lo_o), 64'd12);
    chk("post_hi", 64'(hi_o), 64'd0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the multi-cycle MIPS core, sitting directly downstream of the register file. It consumes the two register read ports (rs → `opa`, rt → `opb`) for MULT/MULTU/DIV/DIVU/MTHI/MTLO and owns the architectural HI/LO registers. The `hi`/`lo` outputs feed the write-back mux for MFHI/MFLO. The control FSM stalls on `busy` and samples the result on `done`.

## Interface
- `WIDTH`, 32: operand width. HI and LO are each `WIDTH` bits.
- `clk` in 1: clock, all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: launch the operation selected by `op`. Accepted only in IDLE.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled with `start`.
- `opa` in WIDTH: rs value (multiplicand/dividend; MTHI/MTLO source).
- `opb` in WIDTH: rt value (multiplier/divisor).
- `mthi` in 1: write `opa` to HI. Accepted only in IDLE.
- `mtlo` in 1: write `opa` to LO. Accepted only in IDLE.
- `busy` out 1: operation in flight; the core must stall MFHI/MFLO/MTHI/MTLO/start.
- `done` out 1: one-cycle pulse, HI/LO hold the new result.
- `div_zero` out 1: pulses with `done` when a DIV/DIVU had `opb`==0.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- States:
  - IDLE → PREP on `start`.
  - PREP → CALC.
  - CALC → FIX when the iteration counter reaches 0.
  - FIX → IDLE.
- PREP:
  - Latch `op`.
  - Take magnitudes of `opa`/`opb` (absolute value for signed ops, raw for unsigned).
  - Record `neg_q` = sa^sb and `neg_r` = sa for signed ops (0 for unsigned).
  - Load counter = WIDTH-1.
- CALC, multiply: radix-2 shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle, WIDTH iterations.
- CALC, divide: restoring divide, remainder WIDTH+1 bits, one quotient bit per cycle, WIDTH iterations.
- FIX, multiply: the 2·WIDTH product is negated if `neg_q`. HI = upper word, LO = lower word.
- FIX, divide: LO = quotient, negated if `neg_q`. HI = remainder, negated if `neg_r`.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000 and HI = 0 (natural two's-complement wrap, no trap).
- Divide by zero: full latency still applies. HI/LO are NOT written. `div_zero` = 1 together with `done`.
- MTHI/MTLO in IDLE: the register updates at the next edge; `done` is not pulsed. `mthi` and `mtlo` may be asserted together.
- Simultaneous `start` and `mthi`/`mtlo` in IDLE: `start` wins and the moves are dropped.
- `start`/`mthi`/`mtlo` while `busy`: ignored, with no effect on the operation in flight.
- `opa`/`opb` are used only in the PREP cycle (captured internally). The core need not hold them afterwards.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, state IDLE, counter 0.
- `rst` mid-operation aborts the operation immediately (asynchronous). No `done` is produced and HI/LO are cleared.
- Let E0 be the edge that samples `start`. The schedule is:
  - PREP at E1.
  - CALC at E2–E33.
  - FIX at E34.
- `busy` is high from after E0 until after E34 (34 cycles).
- `done` and `div_zero` are high for exactly the cycle after E34. In that cycle `busy`=0, and `start` is accepted again.
- MULT/DIV latency is 35 cycles from `start` to result visibility.
- MTHI/MTLO latency is 1 cycle.
- `hi`/`lo` are registered outputs with no combinational path from inputs.

## Configuration
- `MDU_DIV_EN` defined: DIV/DIVU are implemented as described above.
- `MDU_DIV_EN` undefined: the divide datapath is removed. `op`=1x is accepted, goes IDLE→FIX directly, and returns `done` one cycle after E1. HI/LO are unchanged and `div_zero`=0.
- Multiply behaviour is identical in both builds.

## Structure
- `mdu_pkg` holds:
  - op encodings `OP_MULT`/`OP_MULTU`/`OP_DIV`/`OP_DIVU`
  - state encoding `ST_IDLE`/`ST_PREP`/`ST_CALC`/`ST_FIX`
  - iteration count constant `MDU_ITER` = 32
- Sub-module `mdu_step` is combinational: one shift-add or one restore-subtract step selected by an `is_div` input. The top holds the FSM, counter and HI/LO.

## Test plan
- MULT `opa`=0xFFFFFFFE, `opb`=3 → `done` in cycle 35; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. MULT of the same operands → HI=0, LO=1.
- DIV 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 5/0 → `div_zero`=1 with `done`, HI/LO unchanged.
- `mthi` `opa`=0x1234 in IDLE → HI=0x1234 after 1 edge, no `done`. `start` pulsed at cycle 5 of a busy MULT → ignored, single `done` at cycle 35.
- `rst` asserted at cycle 10 of a DIV → `busy`=0 and HI=LO=0 immediately, no `done`. A new MULTU 3×4 then gives LO=12.
